// File: rtl/iq_mac_scheduler_if.sv
// Sample handshakes from the I/Q ADC side plus the control bundle driven to the shared MAC.
// The slave modport is the scheduler; the master modport is the sample sources / MAC side.
interface iq_mac_scheduler_if #(
  parameter int SELW = 3
);
  logic            enable;
  logic            i_valid;
  logic            i_ready;
  logic            q_valid;
  logic            q_ready;
  logic [SELW-1:0] mac_sel;
  logic            mac_ch;
  logic            mac_en;
  logic            mac_clr;
  logic            i_done;
  logic            q_done;
  logic            busy;

  modport slave (
    input  enable, i_valid, q_valid,
    output i_ready, q_ready, mac_sel, mac_ch, mac_en, mac_clr, i_done, q_done, busy
  );

  modport master (
    output enable, i_valid, q_valid,
    input  i_ready, q_ready, mac_sel, mac_ch, mac_en, mac_clr, i_done, q_done, busy
  );
endinterface

// File: rtl/iq_mac_scheduler.sv
// Round-robin I/Q scheduler for one shared symmetric-FIR MAC: accept->done is NPAIR+1 cycles.
// Ready is granted only at idle or on the last phase, so runs chain back-to-back with no bubble.
module iq_mac_scheduler #(
  parameter int NPAIR = 5,
  parameter int SELW  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  iq_mac_scheduler_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SELW-1:0] LAST_PHASE = SELW'(NPAIR - 1);

  state_t          state;
  logic [SELW-1:0] phase;
  logic            ch;
  logic            rr_last;

  logic last_phase;
  logic window;
  logic grant_i;
  logic grant_q;
  logic accept;

  // rr_last: 0 = I, 1 = Q; on contention the channel that did not go last wins
  always_comb begin
    last_phase = (state == RUN) && (phase == LAST_PHASE);
    window     = resetn && bus.enable && ((state == IDLE) || last_phase);
    grant_i    = window && bus.i_valid && (!bus.q_valid || rr_last);
    grant_q    = window && bus.q_valid && (!bus.i_valid || !rr_last);
    accept     = grant_i || grant_q;
  end

  assign bus.i_ready = grant_i;
  assign bus.q_ready = grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      phase       <= '0;
      ch          <= 1'b0;
      rr_last     <= 1'b1;
      bus.mac_sel <= '0;
      bus.mac_ch  <= 1'b0;
      bus.mac_en  <= 1'b0;
      bus.mac_clr <= 1'b0;
      bus.i_done  <= 1'b0;
      bus.q_done  <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      // Done refers to the run finishing now, independent of any new grant
      bus.i_done <= last_phase && !ch;
      bus.q_done <= last_phase && ch;

      if (accept) begin
        state       <= RUN;
        phase       <= '0;
        ch          <= grant_q;
        rr_last     <= grant_q;
        bus.mac_sel <= '0;
        bus.mac_ch  <= grant_q;
        bus.mac_en  <= 1'b1;
        bus.mac_clr <= 1'b1;
        bus.busy    <= 1'b1;
      end else if ((state == RUN) && !last_phase) begin
        phase       <= phase + SELW'(1);
        bus.mac_sel <= phase + SELW'(1);
        bus.mac_en  <= 1'b1;
        bus.mac_clr <= 1'b0;
        bus.busy    <= 1'b1;
      end else begin
        state       <= IDLE;
        phase       <= '0;
        bus.mac_sel <= '0;
        bus.mac_en  <= 1'b0;
        bus.mac_clr <= 1'b0;
        bus.busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iq_mac_scheduler.sv
// Directed plus randomized bench for iq_mac_scheduler against a cycle-indexed schedule model.
module tb_iq_mac_scheduler;

  localparam int NPAIR = 5;
  localparam int SELW  = 3;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  iq_mac_scheduler_if #(.SELW(SELW)) bus ();

  iq_mac_scheduler #(.NPAIR(NPAIR), .SELW(SELW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected MAC activity, indexed by absolute cycle number
  int  cyc      = 0;
  int  last_end = 0;
  bit  rr_last  = 1'b1;
  bit  e_en    [MAXC];
  bit  e_clr   [MAXC];
  bit  e_ch    [MAXC];
  int  e_sel   [MAXC];
  bit  e_idone [MAXC];
  bit  e_qdone [MAXC];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_future();
    for (int k = 0; k < NPAIR + 3; k++) begin
      if (cyc + k < MAXC) begin
        e_en[cyc+k]    = 1'b0;
        e_clr[cyc+k]   = 1'b0;
        e_ch[cyc+k]    = 1'b0;
        e_sel[cyc+k]   = 0;
        e_idone[cyc+k] = 1'b0;
        e_qdone[cyc+k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rst_i_ready", 8'(bus.i_ready), 8'd0);
      check("rst_q_ready", 8'(bus.q_ready), 8'd0);
      check("rst_mac_en",  8'(bus.mac_en),  8'd0);
      check("rst_mac_clr", 8'(bus.mac_clr), 8'd0);
      check("rst_mac_sel", 8'(bus.mac_sel), 8'd0);
      check("rst_mac_ch",  8'(bus.mac_ch),  8'd0);
      check("rst_i_done",  8'(bus.i_done),  8'd0);
      check("rst_q_done",  8'(bus.q_done),  8'd0);
      check("rst_busy",    8'(bus.busy),    8'd0);
      clear_future();
      rr_last  = 1'b1;
      cyc++;
      last_end = cyc;
    end
  endtask

  task automatic step(input bit en, input bit iv, input bit qv);
    bit win;
    bit exp_i;
    bit exp_q;
    @(negedge clk);
    resetn      = 1'b1;
    bus.enable  = en;
    bus.i_valid = iv;
    bus.q_valid = qv;
    #1;
    win   = en && (cyc >= last_end);
    exp_i = win && iv && (!qv || rr_last);
    exp_q = win && qv && (!iv || !rr_last);
    check("i_ready", 8'(bus.i_ready), 8'(exp_i));
    check("q_ready", 8'(bus.q_ready), 8'(exp_q));
    check("mac_en",  8'(bus.mac_en),  8'(e_en[cyc]));
    check("busy",    8'(bus.busy),    8'(e_en[cyc]));
    check("mac_clr", 8'(bus.mac_clr), 8'(e_clr[cyc]));
    check("mac_sel", 8'(bus.mac_sel), 8'(e_sel[cyc]));
    check("i_done",  8'(bus.i_done),  8'(e_idone[cyc]));
    check("q_done",  8'(bus.q_done),  8'(e_qdone[cyc]));
    if (e_en[cyc]) check("mac_ch", 8'(bus.mac_ch), 8'(e_ch[cyc]));
    if (exp_i || exp_q) begin
      rr_last = exp_q;
      for (int k = 0; k < NPAIR; k++) begin
        e_en[cyc+1+k]  = 1'b1;
        e_clr[cyc+1+k] = (k == 0);
        e_sel[cyc+1+k] = k;
        e_ch[cyc+1+k]  = exp_q;
      end
      e_idone[cyc+1+NPAIR] = !exp_q;
      e_qdone[cyc+1+NPAIR] = exp_q;
      last_end = cyc + NPAIR;
    end
    cyc++;
  endtask

  initial begin
    bus.enable  = 1'b1;
    bus.i_valid = 1'b1;
    bus.q_valid = 1'b1;
    for (int k = 0; k < MAXC; k++) begin
      e_en[k] = 1'b0; e_clr[k] = 1'b0; e_ch[k] = 1'b0;
      e_sel[k] = 0; e_idone[k] = 1'b0; e_qdone[k] = 1'b0;
    end

    // Reset held with both valids high, then I must win first
    do_reset(3);
    step(1, 1, 1);
    repeat (7) step(1, 0, 0);

    // Single I sample: sel 0..4, clr on first phase, done six cycles after accept
    step(1, 1, 0);
    repeat (7) step(1, 0, 0);

    // Both channels saturating: alternating grants, no bubbles
    repeat (30) step(1, 1, 1);
    repeat (7) step(1, 0, 0);

    // Q alone keeps winning even though it went last
    repeat (17) step(1, 0, 1);
    repeat (7) step(1, 0, 0);

    // enable dropped at phase 2: run completes, no new grant until re-enabled
    step(1, 1, 0);
    repeat (2) step(1, 0, 0);
    repeat (5) step(0, 1, 1);
    step(1, 1, 1);
    repeat (7) step(1, 0, 0);

    // Reset at phase 3 of a Q run: no done, I wins afterwards
    step(1, 0, 1);
    repeat (3) step(1, 0, 0);
    do_reset(1);
    step(1, 1, 1);
    repeat (7) step(1, 0, 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
